// File: rtl/laser_eval_sched_if.sv
// laser_eval_sched_if: point-load, request/grant and result bundle
// for the shared coverage evaluator (master = requesters, slave = engine).
interface laser_eval_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic                 pt_we;
  logic [3:0]           pt_x;
  logic [3:0]           pt_y;
  logic [NREQ-1:0]      req;
  logic [16*NREQ-1:0]   cand;
  logic [NREQ-1:0]      gnt;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [5:0]           rsp_cnt;
  logic                 busy;

  modport master (
    output pt_we, pt_x, pt_y, req, cand,
    input  gnt, rsp_valid, rsp_id, rsp_cnt, busy
  );

  modport slave (
    input  pt_we, pt_x, pt_y, req, cand,
    output gnt, rsp_valid, rsp_id, rsp_cnt, busy
  );
endinterface

// File: rtl/laser_eval_sched.sv
// laser_eval_sched: arbitrates NREQ searchers onto one point-scan datapath.
// Define LASER_RR_ARB_EN for round-robin; otherwise fixed lowest-index priority.
module laser_eval_sched #(
  parameter int NREQ = 4,
  parameter int NPTS = 40,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              RST,
  laser_eval_sched_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_SCAN  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [5:0] LAST    = 6'(NPTS-1);

  logic [1:0]     state_q, state_d;
  logic [5:0]     wr_ptr_q;
  logic [5:0]     idx_q;
  logic [5:0]     acc_q;
  logic [5:0]     acc_inc;
  logic [3:0]     px_q [NPTS];
  logic [3:0]     py_q [NPTS];
  logic [15:0]    cand_q;
  logic [IDW-1:0] w_q;
  logic [IDW-1:0] w_arb;
  logic [IDW-1:0] rsp_id_q;
  logic [5:0]     rsp_cnt_q;
  logic           any_req;
  logic           pt_wr;
  logic           arb_go;
  logic           hit;

  function automatic logic [8:0] dist2(
    input logic [3:0] cx, input logic [3:0] cy,
    input logic [3:0] px, input logic [3:0] py
  );
    logic [3:0] dx;
    logic [3:0] dy;
    dx = (cx >= px) ? cx - px : px - cx;
    dy = (cy >= py) ? cy - py : py - cy;
    return 9'(dx) * 9'(dx) + 9'(dy) * 9'(dy);
  endfunction

  assign any_req = |bus.req;
  assign pt_wr   = (state_q == S_IDLE) && bus.pt_we;
  assign arb_go  = any_req &&
                   (((state_q == S_IDLE) && !bus.pt_we) ||
                    (state_q == S_RESP));

  // Current point covered by either latched centre
  always_comb begin
    hit = (dist2(cand_q[15:12], cand_q[11:8],
                 px_q[idx_q], py_q[idx_q]) <= 9'd16) ||
          (dist2(cand_q[7:4], cand_q[3:0],
                 px_q[idx_q], py_q[idx_q]) <= 9'd16);
    acc_inc = acc_q + {5'd0, hit};
  end

`ifdef LASER_RR_ARB_EN
  logic [IDW-1:0] rr_ptr_q;

  // Round-robin pick: first requester after the last winner
  always_comb begin
    w_arb = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req[(int'(rr_ptr_q) + k) % NREQ])
        w_arb = IDW'((int'(rr_ptr_q) + k) % NREQ);
    end
  end

  // Remember the last winner
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         rr_ptr_q <= IDW'(NREQ-1);
    else if (arb_go) rr_ptr_q <= w_arb;
  end
`else
  // Fixed priority pick: lowest requesting index
  always_comb begin
    w_arb = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (bus.req[i]) w_arb = IDW'(i);
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (arb_go) state_d = S_GRANT;
      S_GRANT: state_d = S_SCAN;
      S_SCAN:  if (idx_q == LAST) state_d = S_RESP;
      S_RESP:  state_d = arb_go ? S_GRANT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control, candidate latch, scan counter and result registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      cand_q    <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      rsp_id_q  <= '0;
      rsp_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (arb_go) w_q <= w_arb;
      if (state_q == S_GRANT) begin
        cand_q <= bus.cand[16*w_q +: 16];
        idx_q  <= '0;
        acc_q  <= '0;
      end
      if (state_q == S_SCAN) begin
        idx_q <= idx_q + 6'd1;
        acc_q <= acc_inc;
        if (idx_q == LAST) begin
          rsp_cnt_q <= acc_inc;
          rsp_id_q  <= w_q;
        end
      end
    end
  end

  // Point store, written only while idle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < NPTS; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else if (pt_wr) begin
      px_q[wr_ptr_q] <= bus.pt_x;
      py_q[wr_ptr_q] <= bus.pt_y;
      wr_ptr_q <= (wr_ptr_q == LAST) ? 6'd0 : wr_ptr_q + 6'd1;
    end
  end

  assign bus.gnt       = (state_q == S_GRANT) ?
                         ({{(NREQ-1){1'b0}}, 1'b1} << w_q) : '0;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_cnt   = rsp_cnt_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_laser_eval_sched.sv
// tb_laser_eval_sched: random requests against a queue-based
// reference model; a monitor pops expected results on rsp_valid.
module tb_laser_eval_sched;
  localparam int NREQ = 4;
  localparam int NPTS = 40;
  localparam int IDW  = $clog2(NREQ);

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  laser_eval_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus();

  laser_eval_sched #(.NREQ(NREQ), .NPTS(NPTS), .IDW(IDW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    int id;
    int cnt;
    int at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_cnt = 0;
  int   mx[NPTS];
  int   my[NPTS];
  int   mwp;
  int   mrr;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit inr(int cx, int cy, int px, int py);
    return ((cx-px)*(cx-px) + (cy-py)*(cy-py)) <= 16;
  endfunction

  function automatic int cov(logic [15:0] c);
    int n = 0;
    for (int i = 0; i < NPTS; i++) begin
      if (inr(int'(c[15:12]), int'(c[11:8]), mx[i], my[i]) ||
          inr(int'(c[7:4]), int'(c[3:0]), mx[i], my[i]))
        n++;
    end
    return n;
  endfunction

  function automatic int arb(logic [NREQ-1:0] rq);
`ifdef LASER_RR_ARB_EN
    for (int k = 1; k <= NREQ; k++)
      if (rq[(mrr + k) % NREQ]) return (mrr + k) % NREQ;
`else
    for (int i = 0; i < NREQ; i++)
      if (rq[i]) return i;
`endif
    return -1;
  endfunction

  function automatic int ohidx(logic [NREQ-1:0] g);
    int r = -1;
    if ($countones(g) != 1) return -1;
    for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NPTS; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end
    mwp = 0;
    mrr = NREQ - 1;
  endfunction

  // Monitor: every result must match the oldest expectation
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.gnt != '0 && bus.rsp_valid) chk("gnt_rsp_overlap", 1, 0);
      if (bus.rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_id", int'(bus.rsp_id), mon_e.id);
          chk("rsp_cnt", int'(bus.rsp_cnt), mon_e.cnt);
          chk("rsp_time", cyc, mon_e.at);
          last_cnt = mon_e.cnt;
        end
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic push_exp(input int w, input logic [15:0] c);
    sbq.push_back('{w, cov(c), cyc + NPTS + 1});
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((bus.busy || sbq.size() != 0) && g < 500) begin
      tick();
      g++;
    end
    if (g >= 500) chk("idle_timeout", 1, 0);
  endtask

  task automatic write_pt(input int x, input int y);
    bus.pt_we = 1'b1;
    bus.pt_x  = 4'(x);
    bus.pt_y  = 4'(y);
    mx[mwp] = x;
    my[mwp] = y;
    mwp = (mwp + 1) % NPTS;
    tick();
    bus.pt_we = 1'b0;
  endtask

  task automatic wait_gnt(output bit ok);
    int g = 0;
    ok = 1'b0;
    while (g < 200) begin
      tick();
      if (bus.gnt != '0) begin
        ok = 1'b1;
        return;
      end
      g++;
    end
    chk("gnt_timeout", 1, 0);
  endtask

  task automatic issue(input logic [NREQ-1:0] rq,
                       input logic [16*NREQ-1:0] cd);
    logic [NREQ-1:0] pend;
    int c0, prev, w;
    bit ok;
    pend = rq;
    prev = -1;
    bus.cand = cd;
    bus.req  = rq;
    c0 = cyc;
    while (pend != '0) begin
      wait_gnt(ok);
      if (!ok) break;
      w = arb(pend);
      chk("gnt_idx", ohidx(bus.gnt), w);
      if (prev < 0) chk("gnt_latency", cyc - c0, 1);
      else          chk("gnt_gap", cyc - prev, NPTS + 2);
      prev = cyc;
      mrr = w;
      if (w >= 0) push_exp(w, cd[16*w +: 16]);
      pend = pend & ~bus.gnt;
      bus.req = pend;
    end
    bus.req = '0;
    wait_idle();
    repeat (3) tick();
    chk("rsp_hold", int'(bus.rsp_cnt), last_cnt);
  endtask

  function automatic logic [16*NREQ-1:0] rand_cands();
    logic [16*NREQ-1:0] c;
    for (int i = 0; i < NREQ; i++) c[16*i +: 16] = 16'($urandom);
    return c;
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [16*NREQ-1:0] cd;
    int w, prev, ng;
    bit ok;
    bus.pt_we = 1'b0;
    bus.pt_x  = '0;
    bus.pt_y  = '0;
    bus.req   = '0;
    bus.cand  = '0;
    model_reset();
    tick();
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_rsp_cnt", int'(bus.rsp_cnt), 0);
    chk("rst_busy", int'(bus.busy), 0);
    RST = 1'b0;
    tick();

    // All points at (8,8), centre on them
    for (int i = 0; i < NPTS; i++) write_pt(8, 8);
    cd = '0;
    cd[15:0] = 16'h8800;
    issue(4'b0001, cd);

    // Radius boundary
    write_pt(12, 8);
    write_pt(11, 11);
    write_pt(12, 11);
    for (int i = 3; i < NPTS; i++) write_pt(0, 15);
    cd[15:0] = 16'h88F0;
    issue(4'b0001, cd);

    // Random point sets, random request masks
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NPTS; i++)
        write_pt($urandom_range(0, 15), $urandom_range(0, 15));
      issue(4'($urandom_range(1, 15)), rand_cands());
    end

    // pt_we during SCAN is ignored
    cd = rand_cands();
    bus.cand = cd;
    bus.req  = 4'b0001;
    wait_gnt(ok);
    if (ok) begin
      w = arb(4'b0001);
      mrr = w;
      push_exp(0, cd[15:0]);
    end
    bus.req = '0;
    repeat (5) tick();
    bus.pt_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pt_x = 4'($urandom);
      bus.pt_y = 4'($urandom);
      tick();
    end
    bus.pt_we = 1'b0;
    wait_idle();
    write_pt(int'(cd[15:12]), int'(cd[11:8]));
    issue(4'b0001, cd);

    // Candidate change after grant does not affect the result
    cd = rand_cands();
    bus.cand = cd;
    bus.req  = 4'b0001;
    wait_gnt(ok);
    if (ok) begin
      mrr = arb(4'b0001);
      push_exp(0, cd[15:0]);
    end
    bus.req = '0;
    tick();
    bus.cand[15:0] = ~cd[15:0];
    wait_idle();

    // Reset in the middle of a scan
    cd = rand_cands();
    bus.cand = cd;
    bus.req  = 4'b0001;
    wait_gnt(ok);
    if (ok) begin
      mrr = arb(4'b0001);
      push_exp(0, cd[15:0]);
    end
    bus.req = '0;
    repeat (20) tick();
    #2 RST = 1'b1;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_gnt", int'(bus.gnt), 0);
    chk("midrst_rsp_valid", int'(bus.rsp_valid), 0);
    sbq.delete();
    model_reset();
    tick();
    RST = 1'b0;
    repeat (2) tick();
    issue(4'b1001, rand_cands());

    // Wrap-around: 41st write lands on entry 0
    for (int i = 0; i < NPTS; i++) write_pt(15, 15);
    write_pt(8, 8);
    cd = '0;
    cd[15:0] = 16'h8888;
    issue(4'b0001, cd);

    // All requesters held from reset
    RST = 1'b1;
    sbq.delete();
    model_reset();
    cd = rand_cands();
    bus.cand = cd;
    bus.req  = 4'b1111;
    tick();
    RST = 1'b0;
`ifdef LASER_RR_ARB_EN
    ng = 5;
`else
    ng = 3;
`endif
    prev = -1;
    for (int n = 0; n < ng; n++) begin
      wait_gnt(ok);
      if (!ok) break;
      w = arb(4'b1111);
      chk("hold_gnt_idx", ohidx(bus.gnt), w);
      if (prev >= 0) chk("hold_gnt_gap", cyc - prev, NPTS + 2);
      prev = cyc;
      mrr = w;
      if (w >= 0) push_exp(w, cd[16*w +: 16]);
      if (n == ng - 1) bus.req = '0;
    end
    bus.req = '0;
    wait_idle();

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
